// File: rtl/store_queue_param.sv
`default_nettype none
// ============================================================================
// Module      : store_queue_param
// Description : Parametrised in-order store queue. Holds issued stores until
//               ROB retirement, drains retired stores in order to a
//               single-port data memory, forwards the youngest matching
//               store to executing loads, and squashes non-retired stores
//               on branch recovery.
// Revision    : 1.0 - initial release
// ============================================================================
module store_queue_param #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 16,
    parameter int ROB_W  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    stall,
    input  logic                    st_valid,
    input  logic [ADDR_W-1:0]       st_addr,
    input  logic [DATA_W-1:0]       st_data,
    input  logic [ROB_W-1:0]        st_rob,
    input  logic                    retire_st,
    input  logic [ROB_W-1:0]        retire_rob,
    input  logic                    recover,
    input  logic                    ld_valid,
    input  logic [ADDR_W-1:0]       ld_addr,
    input  logic                    mem_ready,
    output logic                    mem_wen,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [DATA_W-1:0]       mem_wdata,
    output logic                    fwd_hit,
    output logic [DATA_W-1:0]       fwd_data,
    output logic                    sq_full,
    output logic                    sq_empty,
    output logic [$clog2(DEPTH):0]  sq_count
);

    localparam int              PW         = $clog2(DEPTH);
    localparam logic [PW:0]     C_FULL     = (PW+1)'(DEPTH);
    localparam logic [PW:0]     C_CNT_ONE  = (PW+1)'(1);
    localparam logic [PW-1:0]   C_PTR_ONE  = PW'(1);

    // Entry storage
    logic [DEPTH-1:0]   r_valid;
    logic [DEPTH-1:0]   r_ready;
    logic [ADDR_W-1:0]  r_addr [DEPTH];
    logic [DATA_W-1:0]  r_data [DEPTH];
    logic [ROB_W-1:0]   r_rob  [DEPTH];

    logic [PW-1:0]      r_head;
    logic [PW-1:0]      r_tail;
    logic [PW:0]        r_count;

    logic               r_fwd_hit;
    logic [DATA_W-1:0]  r_fwd_data;

    logic               w_full;
    logic               w_alloc;
    logic               w_wen;
    logic               w_drain;
    logic [DEPTH-1:0]   w_ready_nxt;
    logic [PW:0]        w_nready;
    logic               w_match;
    logic [DATA_W-1:0]  w_match_data;

    assign w_full  = (r_count == C_FULL);
    assign w_alloc = st_valid && !stall && !recover && !w_full;
    // A load owns the memory port, so it always beats the drain.
    assign w_wen   = r_valid[r_head] && r_ready[r_head] && !ld_valid && !stall && !recover;
    assign w_drain = w_wen && mem_ready;

    // Ready bits after this cycle's retirement (recovery squashes on top of this)
    always_comb begin
        w_ready_nxt = r_ready;
        for (int i = 0; i < DEPTH; i++) begin
            if (retire_st && r_valid[i] && !r_ready[i] && (r_rob[i] == retire_rob)) begin
                w_ready_nxt[i] = 1'b1;
            end
        end
    end

    // Number of retired entries surviving a recovery; they are contiguous from head
    always_comb begin
        w_nready = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_nready = w_nready + {{PW{1'b0}}, (r_valid[i] & w_ready_nxt[i])};
        end
    end

    // Youngest-match search: walk from oldest to tail-1 so the last hit wins
    always_comb begin
        w_match      = 1'b0;
        w_match_data = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (r_valid[r_tail - PW'(i + 1)] && (r_addr[r_tail - PW'(i + 1)] == ld_addr)) begin
                w_match      = 1'b1;
                w_match_data = r_data[r_tail - PW'(i + 1)];
            end
        end
    end

    // Entry flags, pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            r_ready <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (recover) begin
            r_valid <= r_valid & w_ready_nxt;
            r_ready <= r_valid & w_ready_nxt;
            r_tail  <= r_head + w_nready[PW-1:0];
            r_count <= w_nready;
        end else begin
            r_ready <= w_ready_nxt;
            if (w_drain) begin
                r_valid[r_head] <= 1'b0;
                r_ready[r_head] <= 1'b0;
                r_head          <= r_head + C_PTR_ONE;
            end
            if (w_alloc) begin
                r_valid[r_tail] <= 1'b1;
                r_ready[r_tail] <= 1'b0;
                r_tail          <= r_tail + C_PTR_ONE;
            end
            if (w_alloc && !w_drain) begin
                r_count <= r_count + C_CNT_ONE;
            end else if (!w_alloc && w_drain) begin
                r_count <= r_count - C_CNT_ONE;
            end
        end
    end

    // Payload write at the tail; payload is don't-care until valid is set
    always_ff @(posedge clk) begin
        if (w_alloc) begin
            r_addr[r_tail] <= st_addr;
            r_data[r_tail] <= st_data;
            r_rob[r_tail]  <= st_rob;
        end
    end

    // Registered forwarding result, aligned with memory read latency
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fwd_hit  <= 1'b0;
            r_fwd_data <= '0;
        end else begin
            r_fwd_hit  <= ld_valid && w_match;
            r_fwd_data <= (ld_valid && w_match) ? w_match_data : '0;
        end
    end

    assign mem_wen   = w_wen;
    assign mem_addr  = r_addr[r_head];
    assign mem_wdata = r_data[r_head];
    assign fwd_hit   = r_fwd_hit;
    assign fwd_data  = r_fwd_data;
    assign sq_full   = w_full;
    assign sq_empty  = (r_count == '0);
    assign sq_count  = r_count;

endmodule
`default_nettype wire

// File: tb/tb_store_queue_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_store_queue_param
// Description : Self-checking bench for store_queue_param: table vectors,
//               directed corner sequences and random traffic against a
//               queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_store_queue_param;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst, stall, st_valid, retire_st, recover, ld_valid, mem_ready;
    logic [15:0] st_addr, ld_addr;
    logic [31:0] st_data;
    logic [3:0]  st_rob, retire_rob;
    logic        mem_wen, fwd_hit, sq_full, sq_empty;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata, fwd_data;
    logic [3:0]  sq_count;

    always #5 clk = ~clk;

    store_queue_param #(.DEPTH(DEPTH), .DATA_W(32), .ADDR_W(16), .ROB_W(4)) dut (
        .clk(clk), .rst(rst), .stall(stall),
        .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_rob(st_rob),
        .retire_st(retire_st), .retire_rob(retire_rob), .recover(recover),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .mem_ready(mem_ready),
        .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .fwd_hit(fwd_hit), .fwd_data(fwd_data),
        .sq_full(sq_full), .sq_empty(sq_empty), .sq_count(sq_count)
    );

    // Reference model: oldest entry at index 0
    typedef struct {
        logic [15:0] addr;
        logic [31:0] data;
        logic [3:0]  rob;
        bit          rdy;
    } ent_t;

    ent_t        q[$];
    logic        m_hit   = 1'b0;
    logic [31:0] m_fdata = '0;
    logic [3:0]  tagctr  = '0;
    logic        s_wen;
    logic [15:0] s_addr;
    bit          found;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic        sv;
        logic [15:0] sa;
        logic [31:0] sd;
        logic [3:0]  sr;
        logic        rs;
        logic [3:0]  rr;
        logic        lv;
        logic [15:0] la;
        logic        mr;
        logic        e_wen;
        logic [15:0] e_addr;
        logic [3:0]  e_cnt;
        logic        e_hit;
        logic [31:0] e_fd;
    } vec_t;

    vec_t tbl[31];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic idle();
        rst = 1'b0; stall = 1'b0; st_valid = 1'b0; st_addr = '0; st_data = '0; st_rob = '0;
        retire_st = 1'b0; retire_rob = '0; recover = 1'b0; ld_valid = 1'b0; ld_addr = '0;
        mem_ready = 1'b0;
    endtask

    // One clock cycle, entered and left on a negedge with inputs already set
    task automatic tick();
        bit          ewen, full, drn, alc, nh;
        logic [31:0] nd;
        ent_t        keep[$];
        full = (q.size() == DEPTH);
        ewen = (q.size() > 0) && q[0].rdy && !ld_valid && !stall && !recover;
        #1;
        s_wen  = mem_wen;
        s_addr = mem_addr;
        chk("mem_wen", 64'(mem_wen), 64'(ewen));
        if (q.size() > 0) begin
            chk("mem_addr", 64'(mem_addr), 64'(q[0].addr));
            chk("mem_wdata", 64'(mem_wdata), 64'(q[0].data));
        end
        nh = 1'b0;
        nd = '0;
        if (ld_valid) foreach (q[i]) if (q[i].addr == ld_addr) begin nh = 1'b1; nd = q[i].data; end
        drn = ewen && mem_ready;
        alc = st_valid && !stall && !recover && !full;
        if (retire_st) foreach (q[i]) if (!q[i].rdy && q[i].rob == retire_rob) q[i].rdy = 1'b1;
        if (rst) begin
            q.delete();
            nh = 1'b0;
            nd = '0;
        end else if (recover) begin
            foreach (q[i]) if (q[i].rdy) keep.push_back(q[i]);
            q = keep;
        end else begin
            if (drn) void'(q.pop_front());
            if (alc) begin
                q.push_back('{st_addr, st_data, st_rob, 1'b0});
                tagctr++;
            end
        end
        m_hit   = nh;
        m_fdata = nd;
        @(posedge clk);
        @(negedge clk);
        chk("sq_count", 64'(sq_count), 64'(q.size()));
        chk("sq_full", 64'(sq_full), 64'(q.size() == DEPTH));
        chk("sq_empty", 64'(sq_empty), 64'(q.size() == 0));
        chk("fwd_hit", 64'(fwd_hit), 64'(m_hit));
        chk("fwd_data", 64'(fwd_data), 64'(m_fdata));
    endtask

    task automatic store(input logic [15:0] a, input logic [31:0] d, input logic [3:0] r);
        idle();
        st_valid = 1'b1; st_addr = a; st_data = d; st_rob = r;
        tick();
    endtask

    task automatic retire(input logic [3:0] r);
        idle();
        retire_st = 1'b1; retire_rob = r;
        tick();
    endtask

    initial begin
        // Vector table: fill, overflow, retire, drain, youngest-match forwarding
        for (int i = 0; i < 31; i++) tbl[i] = '0;
        for (int i = 0; i < 8; i++) begin
            tbl[i].sv = 1'b1; tbl[i].sa = 16'h10 + 16'(i); tbl[i].sd = 32'hA0 + 32'(i);
            tbl[i].sr = 4'(i); tbl[i].e_cnt = 4'(i + 1);
        end
        tbl[8].sv = 1'b1; tbl[8].sa = 16'h18; tbl[8].sd = 32'hBAD; tbl[8].sr = 4'd8; tbl[8].e_cnt = 4'd8;
        for (int i = 9; i <= 16; i++) begin
            tbl[i].rs = 1'b1; tbl[i].rr = 4'(i - 9); tbl[i].e_cnt = 4'd8;
            tbl[i].e_wen = (i > 9); tbl[i].e_addr = 16'h10;
        end
        for (int i = 17; i <= 24; i++) begin
            tbl[i].mr = 1'b1; tbl[i].e_wen = 1'b1; tbl[i].e_addr = 16'h10 + 16'(i - 17);
            tbl[i].e_cnt = 4'(24 - i);
        end
        tbl[25].mr = 1'b1;
        tbl[26].sv = 1'b1; tbl[26].sa = 16'h40; tbl[26].sd = 32'h1111; tbl[26].sr = 4'd0; tbl[26].e_cnt = 4'd1;
        tbl[27].sv = 1'b1; tbl[27].sa = 16'h40; tbl[27].sd = 32'h2222; tbl[27].sr = 4'd1; tbl[27].e_cnt = 4'd2;
        tbl[28].lv = 1'b1; tbl[28].la = 16'h40; tbl[28].e_cnt = 4'd2; tbl[28].e_hit = 1'b1; tbl[28].e_fd = 32'h2222;
        tbl[29].lv = 1'b1; tbl[29].la = 16'h44; tbl[29].e_cnt = 4'd2;
        tbl[30].e_cnt = 4'd2;

        // Reset state
        idle();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_count", 64'(sq_count), 64'(0));
        chk("rst_empty", 64'(sq_empty), 64'(1));
        chk("rst_full", 64'(sq_full), 64'(0));
        chk("rst_wen", 64'(mem_wen), 64'(0));
        chk("rst_hit", 64'(fwd_hit), 64'(0));
        chk("rst_fdata", 64'(fwd_data), 64'(0));

        foreach (tbl[i]) begin
            idle();
            st_valid = tbl[i].sv; st_addr = tbl[i].sa; st_data = tbl[i].sd; st_rob = tbl[i].sr;
            retire_st = tbl[i].rs; retire_rob = tbl[i].rr;
            ld_valid = tbl[i].lv; ld_addr = tbl[i].la; mem_ready = tbl[i].mr;
            tick();
            chk($sformatf("vec%0d_wen", i), 64'(s_wen), 64'(tbl[i].e_wen));
            if (tbl[i].e_wen) chk($sformatf("vec%0d_addr", i), 64'(s_addr), 64'(tbl[i].e_addr));
            chk($sformatf("vec%0d_cnt", i), 64'(sq_count), 64'(tbl[i].e_cnt));
            chk($sformatf("vec%0d_hit", i), 64'(fwd_hit), 64'(tbl[i].e_hit));
            chk($sformatf("vec%0d_fdata", i), 64'(fwd_data), 64'(tbl[i].e_fd));
        end

        // Backpressure: held request, then load priority, then drain
        retire(4'd0);
        for (int k = 0; k < 3; k++) begin
            idle();
            tick();
            chk("bp_hold_wen", 64'(s_wen), 64'(1));
            chk("bp_hold_addr", 64'(s_addr), 64'(16'h40));
            chk("bp_hold_cnt", 64'(sq_count), 64'(2));
        end
        idle(); ld_valid = 1'b1; ld_addr = 16'h99; mem_ready = 1'b1;
        tick();
        chk("bp_ld_prio_wen", 64'(s_wen), 64'(0));
        chk("bp_ld_prio_cnt", 64'(sq_count), 64'(2));
        idle(); mem_ready = 1'b1;
        tick();
        chk("bp_drain_wen", 64'(s_wen), 64'(1));
        chk("bp_drain_cnt", 64'(sq_count), 64'(1));

        // Recovery rollback
        idle(); rst = 1'b1; tick();
        for (int k = 0; k < 5; k++) store(16'h50 + 16'(k), 32'h500 + 32'(k), 4'(k));
        retire(4'd0);
        retire(4'd1);
        idle(); recover = 1'b1; st_valid = 1'b1; st_addr = 16'hEE; st_data = 32'hEE; st_rob = 4'd9;
        tick();
        chk("rec_cnt", 64'(sq_count), 64'(2));
        store(16'h60, 32'h600, 4'd5);
        chk("rec_alloc_cnt", 64'(sq_count), 64'(3));
        idle(); retire_st = 1'b1; retire_rob = 4'd5; recover = 1'b1;
        tick();
        chk("rec_same_cnt", 64'(sq_count), 64'(3));
        for (int k = 0; k < 3; k++) begin
            idle(); mem_ready = 1'b1;
            tick();
            chk("rec_drain_addr", 64'(s_addr), 64'((k == 2) ? 16'h60 : 16'h50 + 16'(k)));
        end

        // Move pointers to index 6, then straddle 7->0 with 4 entries
        for (int k = 0; k < 3; k++) store(16'h30 + 16'(k), 32'h300 + 32'(k), 4'(6 + k));
        for (int k = 0; k < 3; k++) retire(4'(6 + k));
        for (int k = 0; k < 3; k++) begin idle(); mem_ready = 1'b1; tick(); end
        store(16'h77, 32'h7006, 4'd10);
        store(16'h70, 32'h7007, 4'd11);
        store(16'h72, 32'h7000, 4'd12);
        store(16'h70, 32'h7001, 4'd13);
        retire(4'd10);
        idle(); mem_ready = 1'b1; st_valid = 1'b1; st_addr = 16'h73; st_data = 32'h7302; st_rob = 4'd14;
        tick();
        chk("wrap_both_wen", 64'(s_wen), 64'(1));
        chk("wrap_both_cnt", 64'(sq_count), 64'(4));
        idle(); ld_valid = 1'b1; ld_addr = 16'h70;
        tick();
        chk("wrap_fwd_hit", 64'(fwd_hit), 64'(1));
        chk("wrap_fwd_data", 64'(fwd_data), 64'(32'h7001));
        idle(); st_valid = 1'b1; st_addr = 16'h75; st_data = 32'h75; st_rob = 4'd15;
        ld_valid = 1'b1; ld_addr = 16'h75;
        tick();
        chk("alloc_invisible_hit", 64'(fwd_hit), 64'(0));

        // Synchronous reset while a drain request is up
        retire(4'd11);
        idle();
        #1;
        chk("rst_pre_wen", 64'(mem_wen), 64'(1));
        rst = 1'b1;
        #2;
        chk("rst_sync_wen", 64'(mem_wen), 64'(1));
        chk("rst_sync_cnt", 64'(sq_count), 64'(5));
        tick();
        chk("rst_post_wen", 64'(mem_wen), 64'(0));
        chk("rst_post_empty", 64'(sq_empty), 64'(1));
        chk("rst_post_hit", 64'(fwd_hit), 64'(0));

        // Random traffic against the model; retirement stays in order
        tagctr = '0;
        for (int n = 0; n < 1500; n++) begin
            idle();
            st_valid   = ($urandom % 5) < 3;
            st_addr    = 16'h100 + 16'($urandom % 8);
            st_data    = $urandom;
            st_rob     = tagctr;
            retire_st  = ($urandom % 3) == 0;
            retire_rob = 4'($urandom % 16);
            found = 1'b0;
            foreach (q[i]) if (!found && !q[i].rdy) begin retire_rob = q[i].rob; found = 1'b1; end
            recover    = ($urandom % 24) == 0;
            ld_valid   = ($urandom % 3) == 0;
            ld_addr    = 16'h100 + 16'($urandom % 8);
            mem_ready  = ($urandom % 2) == 0;
            stall      = ($urandom % 10) == 0;
            rst        = ($urandom % 400) == 0;
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/store_queue_param.md
Name: store_queue_param

Overview:
- Parametrised in-order store queue for the OoO pipeline's load/store unit; successor to the fixed 4-entry store queue.
- Buffers issued stores until ROB retirement, then drains them in order to the single-port data memory through a ready/valid handshake.
- Forwards the youngest matching store to executing loads.
- On branch recovery, squashes every non-retired store in one cycle and rolls the tail back.

Parameters:
DEPTH, 8, number of entries; power of two, at least 2
DATA_W, 32, store data width
ADDR_W, 16, memory address width held per entry
ROB_W, 4, ROB tag width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
stall  in  1  pipeline hazard stall; blocks allocate and drain
st_valid  in  1  store issued this cycle
st_addr  in  ADDR_W  effective store address
st_data  in  DATA_W  store data
st_rob  in  ROB_W  ROB tag of the store
retire_st  in  1  ROB retiring a store this cycle
retire_rob  in  ROB_W  tag being retired
recover  in  1  misprediction recovery; squash non-retired entries
ld_valid  in  1  load executing this cycle; owns the memory port
ld_addr  in  ADDR_W  load address
mem_ready  in  1  data memory accepts a write this cycle
mem_wen  out  1  drain request for the head entry
mem_addr  out  ADDR_W  head entry address
mem_wdata  out  DATA_W  head entry data
fwd_hit  out  1  registered: previous-cycle load matched a queued store
fwd_data  out  DATA_W  registered forwarded data
sq_full  out  1  count equals DEPTH
sq_empty  out  1  count equals 0
sq_count  out  log2(DEPTH)+1  occupancy

Behaviour:
- Storage is a circular buffer with head/tail pointers of log2(DEPTH) bits that wrap modulo DEPTH. Occupancy is tracked by a separate counter of log2(DEPTH)+1 bits. Each entry holds valid, ready (retired), addr, data and rob.
- Reset (rst high at posedge): all entry valid/ready bits, head, tail, count, fwd_hit and fwd_data are cleared to 0. mem_wen is 0. sq_empty is 1. A reset asserted mid-drain abandons the drain with no replay.
- Allocate:
  - Condition: st_valid && !stall && !recover && !sq_full.
  - Action: write the tail entry (valid=1, ready=0) and increment the tail.
  - The full check uses the current count, so a same-cycle drain does not free space. A store offered while full is dropped; upstream must honour sq_full.
- Retire:
  - Condition: retire_st. Any valid entry with ready=0 and rob==retire_rob gets ready=1.
  - A tag with no matching entry is ignored. Retire is not gated by stall.
  - Retirement is in order, so ready entries always form a contiguous run from the head.
- Drain:
  - mem_wen = head valid && head ready && !ld_valid && !stall && !recover. mem_addr and mem_wdata always reflect the head entry.
  - On mem_wen && mem_ready: clear the head valid and ready bits and increment the head.
  - If mem_ready is low, hold the request; head, addr and data stay stable.
  - A load always has priority over the drain for the memory port.
- Recover:
  - Squash is applied after the same-cycle retire update: every valid entry with ready=0 is invalidated.
  - tail <= head + (number of ready entries); count <= number of ready entries.
  - Same-cycle allocate and drain are suppressed.
- Count: +1 on allocate only, -1 on drain only, unchanged when both occur, overwritten on recover.
- Forwarding:
  - When ld_valid, compare ld_addr against every valid entry, ready or not.
  - Select the youngest match, i.e. the matching entry closest to the tail, walking backwards from tail-1 with wrap.
  - A same-cycle allocate is not visible to the comparison.
  - Next cycle: fwd_hit = match found, fwd_data = the selected entry's data (0 on miss). This one-cycle latency aligns with memory read latency.
  - When ld_valid is low, fwd_hit is cleared to 0 the next cycle.

Test Plan:
- Fill then drain: allocate 8 stores (addr 0x10..0x17) → sq_full=1 and sq_count=8; a 9th store is dropped. Retire all 8, hold mem_ready=1 → 8 in-order writes, 0x10 first, ending with sq_empty=1 and head/tail wrapped back to 0.
- Youngest-match forwarding: stores A=0x40/0x1111, B=0x40/0x2222, then load 0x40 → next cycle fwd_hit=1, fwd_data=0x2222. Load 0x44 → fwd_hit=0.
- Backpressure and priority: retired head entry with mem_ready=0 for 3 cycles → mem_wen stays high with stable addr/data. ld_valid=1 in the 4th cycle → mem_wen=0. Head advances only once ld_valid=0 and mem_ready=1.
- Recovery rollback: 5 stores queued, first 2 retired, recover=1 → sq_count=2 and tail=head+2. The next allocated store lands directly after the 2 retired entries. Retire and recover in the same cycle on the 3rd entry → that entry survives and count=3.
- Wrap-around allocate+drain: with count=4 straddling index 7→0, allocate and drain in the same cycle → count stays 4, both pointers advance modulo 8, and forwarding still selects the youngest entry across the wrap.
- Synchronous reset mid-drain: assert rst while mem_wen=1 → on the next posedge mem_wen=0, sq_empty=1, fwd_hit=0. rst held low between edges has no asynchronous effect.
